// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, tag-entry bit positions, controller state
// encoding and a line word-select helper for the instruction-cache controller.
package icache_pkg;

  localparam int SETS        = 128;
  localparam int INDEX_W     = 7;
  localparam int TAG_W       = 21;
  localparam int LINE_W      = 128;
  localparam int MEM_W       = 64;
  localparam int TAG_ENTRY_W = 23;

  // Tag entry layout: {dirty, valid, tag[20:0]}
  localparam int DIRTY_BIT = 22;
  localparam int VALID_BIT = 21;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    FILL
  } state_t;

  // Pick one 32-bit word out of a cache line (sel = addr[3:2]).
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [1:0] sel);
    return line[32*sel +: 32];
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: all bus signals around the cache controller.
//   CPU side    : req_valid/req_ready/req_addr, resp_valid/resp_data
//   Tag RAMs    : tag_en, tag_we[1:0], tag_addr, tag_wdata, tag_q0/tag_q1
//   Data RAM    : data_cen_n, data_wen_n, data_addr, data_wsel,
//                 data_bwen_n, data_wdata, data_q0/data_q1 (active-low controls)
//   Memory side : mem_req_valid/ready/addr, mem_resp_valid/data
// modport master = controller view, modport slave = environment view.
interface icache_if;
  import icache_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_addr;
  logic                   resp_valid;
  logic [31:0]            resp_data;

  logic                   tag_en;
  logic [1:0]             tag_we;
  logic [INDEX_W-1:0]     tag_addr;
  logic [TAG_W-1:0]       tag_wdata;
  logic [TAG_ENTRY_W-1:0] tag_q0;
  logic [TAG_ENTRY_W-1:0] tag_q1;

  logic                   data_cen_n;
  logic                   data_wen_n;
  logic [INDEX_W-1:0]     data_addr;
  logic                   data_wsel;
  logic [LINE_W-1:0]      data_bwen_n;
  logic [LINE_W-1:0]      data_wdata;
  logic [LINE_W-1:0]      data_q0;
  logic [LINE_W-1:0]      data_q1;

  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [31:0]            mem_req_addr;
  logic                   mem_resp_valid;
  logic [MEM_W-1:0]       mem_resp_data;

  modport master (
    input  req_valid, req_addr, tag_q0, tag_q1, data_q0, data_q1,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data,
           tag_en, tag_we, tag_addr, tag_wdata,
           data_cen_n, data_wen_n, data_addr, data_wsel, data_bwen_n, data_wdata,
           mem_req_valid, mem_req_addr
  );

  modport slave (
    output req_valid, req_addr, tag_q0, tag_q1, data_q0, data_q1,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data,
           tag_en, tag_we, tag_addr, tag_wdata,
           data_cen_n, data_wen_n, data_addr, data_wsel, data_bwen_n, data_wdata,
           mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/icache_refill_buf.sv
// icache_refill_buf: assembles a 128-bit line from a 2-beat 64-bit burst.
//   clk, rst   : clock, synchronous active-high reset
//   start      : burst request handshake, rewinds the beat counter
//   beat_valid : a beat is present on beat_data this cycle
//   beat_data  : 64-bit beat (beat0 -> line[63:0], beat1 -> line[127:64])
//   done       : the beat being captured this cycle is the last one
//   line       : assembled line, complete the cycle after done
module icache_refill_buf
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              beat_valid,
  input  logic [MEM_W-1:0]  beat_data,
  output logic              done,
  output logic [LINE_W-1:0] line
);

  logic beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= 1'b0;
      line     <= '0;
    end else if (start) begin
      beat_cnt <= 1'b0;
    end else if (beat_valid) begin
      if (beat_cnt) line[127:64] <= beat_data;
      else          line[63:0]   <= beat_data;
      beat_cnt <= ~beat_cnt;
    end
  end

  assign done = beat_valid && beat_cnt;

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: two-way set-associative read-only instruction-cache controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : icache_if.master -- CPU request/response, tag RAMs, data RAM,
//              memory burst-read port
// After reset the tag RAMs are swept invalid (INIT), then each fetch is looked
// up; a miss picks a victim, refills the line with a 2-beat burst and writes it.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  icache_if.master bus
);

  state_t             state, next_state;
  logic [INDEX_W-1:0] init_cnt;
  logic               rr;
  logic [31:2]        addr_q;
  logic               victim_q;
  logic               resp_valid_q;
  logic [31:0]        resp_data_q;

  logic               hit0, hit1;
  logic               victim_sel;
  logic               buf_start, buf_beat, buf_done;
  logic [LINE_W-1:0]  line;

  assign hit0 = bus.tag_q0[VALID_BIT] && (bus.tag_q0[TAG_W-1:0] == addr_q[31:11]);
  assign hit1 = bus.tag_q1[VALID_BIT] && (bus.tag_q1[TAG_W-1:0] == addr_q[31:11]);

  // Fill an invalid way first; only when both are live does round-robin decide.
  assign victim_sel = !bus.tag_q0[VALID_BIT] ? 1'b0 :
                      !bus.tag_q1[VALID_BIT] ? 1'b1 : rr;

  assign buf_start = (state == MISS_REQ) && bus.mem_req_ready;
  assign buf_beat  = (state == REFILL) && bus.mem_resp_valid;

  icache_refill_buf u_refill_buf (
    .clk        (clk),
    .rst        (rst),
    .start      (buf_start),
    .beat_valid (buf_beat),
    .beat_data  (bus.mem_resp_data),
    .done       (buf_done),
    .line       (line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      init_cnt     <= '0;
      rr           <= 1'b0;
      addr_q       <= '0;
      victim_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state        <= next_state;
      resp_valid_q <= 1'b0;
      if (state == INIT) init_cnt <= init_cnt + 7'd1;
      if (state == IDLE && bus.req_valid) addr_q <= bus.req_addr[31:2];
      if (state == LOOKUP) begin
        if (hit0) begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= line_word(bus.data_q0, addr_q[3:2]);
        end else if (hit1) begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= line_word(bus.data_q1, addr_q[3:2]);
        end else begin
          victim_q <= victim_sel;
          if (bus.tag_q0[VALID_BIT] && bus.tag_q1[VALID_BIT]) rr <= ~rr;
        end
      end
      if (state == FILL) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= line_word(line, addr_q[3:2]);
      end
    end
  end

  // IDLE drives the RAM index straight from req_addr so the read data is
  // ready in LOOKUP; every other state uses the latched address.
  always_comb begin
    next_state        = state;
    bus.req_ready     = 1'b0;
    bus.tag_en        = 1'b0;
    bus.tag_we        = 2'b00;
    bus.tag_addr      = addr_q[10:4];
    bus.tag_wdata     = addr_q[31:11];
    bus.data_cen_n    = 1'b1;
    bus.data_wen_n    = 1'b1;
    bus.data_addr     = addr_q[10:4];
    bus.data_wsel     = victim_q;
    bus.data_wdata    = line;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = {addr_q[31:4], 4'b0000};
    case (state)
      INIT: begin
        bus.tag_en    = 1'b1;
        bus.tag_we    = 2'b11;
        bus.tag_addr  = init_cnt;
        bus.tag_wdata = '0;
        if (init_cnt == 7'(SETS - 1)) next_state = IDLE;
      end
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          bus.tag_en     = 1'b1;
          bus.data_cen_n = 1'b0;
          bus.tag_addr   = bus.req_addr[10:4];
          bus.data_addr  = bus.req_addr[10:4];
          next_state     = LOOKUP;
        end
      end
      LOOKUP: next_state = (hit0 || hit1) ? IDLE : MISS_REQ;
      MISS_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) next_state = REFILL;
      end
      REFILL: if (buf_done) next_state = FILL;
      FILL: begin
        bus.data_cen_n = 1'b0;
        bus.data_wen_n = 1'b0;
        bus.tag_en     = 1'b1;
        bus.tag_we     = victim_q ? 2'b10 : 2'b01;
        next_state     = IDLE;
      end
      default: next_state = INIT;
    endcase
    // Nothing is written or requested while reset is asserted.
    if (rst) begin
      bus.req_ready     = 1'b0;
      bus.tag_en        = 1'b0;
      bus.tag_we        = 2'b00;
      bus.data_cen_n    = 1'b1;
      bus.data_wen_n    = 1'b1;
      bus.mem_req_valid = 1'b0;
    end
  end

  assign bus.data_bwen_n = '0;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;

  // A line is only ever installed once, so two ways can never both hit.
  a_single_hit : assert property (@(posedge clk) disable iff (rst)
    !(state == LOOKUP && hit0 && hit1));

  // Read-only cache: no entry may ever come back dirty.
  a_never_dirty : assert property (@(posedge clk) disable iff (rst)
    (state == LOOKUP) |-> !(bus.tag_q0[DIRTY_BIT] || bus.tag_q1[DIRTY_BIT]));

endmodule
